// File: rtl/darkbus_arb.sv
// Two-master arbiter for the darkbus provider: instruction fetch (m0) vs load/store (m1).
// Data side wins ties until a starvation limit; a watchdog ends transactions the provider never completes.

module darkbus_arb #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        m0_en,
    input  logic        m0_rw,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_valid,
    input  logic        m1_en,
    input  logic        m1_rw,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_valid,
    output logic        s_en,
    output logic        s_rw,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_valid,
    output logic        owner,
    output logic        busy,
    output logic        tmo
);

    localparam int ST_W      = $clog2(STARVE_MAX + 1);
    localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_MAX);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);
    localparam logic            WD_ON   = (TIMEOUT > 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ST_W-1:0]   streak_r;
    logic [WD_W-1:0]   wd_r;
    logic              owner_r;
    logic              s_en_r;
    logic              s_rw_r;
    logic [3:0]        s_be_r;
    logic [31:0]       s_addr_r;
    logic [31:0]       s_wdata_r;

    logic              req_s;
    logic              grant_m1_s;
    logic              done_s;
    logic              wd_exp_s;
    logic              finish_s;
    logic [31:0]       rsp_data_s;

    // m1 keeps priority on a tie only while m0 has not yet been passed over STARVE_MAX times
    assign req_s      = m0_en | m1_en;
    assign grant_m1_s = m1_en & (~m0_en | (streak_r != ST_MAX));
    assign done_s     = (state_r == ST_BUSY) & s_valid;
    assign wd_exp_s   = WD_ON & (state_r == ST_BUSY) & ~s_valid & (wd_r == WD_LAST);
    assign finish_s   = done_s | wd_exp_s;

    assign s_en    = s_en_r;
    assign s_rw    = s_rw_r;
    assign s_be    = s_be_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign owner   = owner_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!res) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (finish_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Provider request registers: latched from the winner on grant, held for the whole transaction
    always_ff @(posedge clk) begin
        if (!res) begin
            s_en_r    <= 1'b0;
            s_rw_r    <= 1'b0;
            s_be_r    <= 4'b0000;
            s_addr_r  <= 32'h0000_0000;
            s_wdata_r <= 32'h0000_0000;
            owner_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            s_en_r    <= 1'b1;
            s_rw_r    <= grant_m1_s ? m1_rw    : m0_rw;
            s_be_r    <= grant_m1_s ? m1_be    : m0_be;
            s_addr_r  <= grant_m1_s ? m1_addr  : m0_addr;
            s_wdata_r <= grant_m1_s ? m1_wdata : m0_wdata;
            owner_r   <= grant_m1_s;
        end else if (finish_s) begin
            s_en_r    <= 1'b0;
        end else begin
            s_en_r    <= s_en_r;
        end
    end

    // Starvation streak: counts m1 grants that bypassed a pending m0
    always_ff @(posedge clk) begin
        if (!res) begin
            streak_r <= '0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            if (grant_m1_s && m0_en) begin
                streak_r <= (streak_r == ST_MAX) ? streak_r : (streak_r + ST_W'(1'b1));
            end else begin
                streak_r <= '0;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

    // Watchdog: zero in the first BUSY cycle, advances each BUSY cycle that does not finish
    always_ff @(posedge clk) begin
        if (!res) begin
            wd_r <= '0;
        end else if ((state_r == ST_BUSY) && !finish_s) begin
            wd_r <= wd_r + WD_W'(1'b1);
        end else begin
            wd_r <= '0;
        end
    end

    // Completion routing to the owner; a timeout returns all-ones as read data
    always_comb begin
        m0_valid   = 1'b0;
        m1_valid   = 1'b0;
        m0_rdata   = 32'h0000_0000;
        m1_rdata   = 32'h0000_0000;
        rsp_data_s = s_valid ? s_rdata : 32'hFFFF_FFFF;
        busy       = (state_r == ST_BUSY);
        tmo        = wd_exp_s;
        if (finish_s) begin
            if (owner_r) begin
                m1_valid = 1'b1;
                m1_rdata = rsp_data_s;
            end else begin
                m0_valid = 1'b1;
                m0_rdata = rsp_data_s;
            end
        end else begin
            m0_valid = 1'b0;
            m1_valid = 1'b0;
        end
    end

    darkbus_arb_chk u_chk (
        .clk      (clk),
        .res      (res),
        .m0_valid (m0_valid),
        .m1_valid (m1_valid),
        .m0_rdata (m0_rdata),
        .m1_rdata (m1_rdata),
        .s_en     (s_en),
        .busy     (busy),
        .tmo      (tmo)
    );

endmodule

// Protocol invariants of the arbiter outputs.
module darkbus_arb_chk (
    input  logic        clk,
    input  logic        res,
    input  logic        m0_valid,
    input  logic        m1_valid,
    input  logic [31:0] m0_rdata,
    input  logic [31:0] m1_rdata,
    input  logic        s_en,
    input  logic        busy,
    input  logic        tmo
);

    a_one_valid: assert property (@(posedge clk) disable iff (!res) !(m0_valid && m1_valid))
        else $error("both completion strobes high");
    a_sen_busy: assert property (@(posedge clk) disable iff (!res) (s_en == busy))
        else $error("s_en disagrees with busy");
    a_tmo_busy: assert property (@(posedge clk) disable iff (!res) (tmo |-> busy))
        else $error("tmo outside BUSY");
    a_m0_quiet: assert property (@(posedge clk) disable iff (!res) (!m0_valid |-> (m0_rdata == 32'h0000_0000)))
        else $error("m0_rdata nonzero without valid");
    a_m1_quiet: assert property (@(posedge clk) disable iff (!res) (!m1_valid |-> (m1_rdata == 32'h0000_0000)))
        else $error("m1_rdata nonzero without valid");

endmodule

// File: tb/tb_darkbus_arb.sv
// Directed bench for darkbus_arb (TIMEOUT=8, STARVE_MAX=4): inputs driven on the falling edge,
// outputs sampled 1ns later, each scenario task checks its own hand-computed expectations.

module tb_darkbus_arb;

    logic        clk;
    logic        res;
    logic        m0_en, m0_rw, m1_en, m1_rw;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_valid, m1_valid;
    logic        s_en, s_rw;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_valid;
    logic        owner, busy, tmo;

    int n_checks = 0;
    int n_pass   = 0;

    darkbus_arb #(.TIMEOUT(8), .STARVE_MAX(4)) dut (
        .clk(clk), .res(res),
        .m0_en(m0_en), .m0_rw(m0_rw), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_valid(m0_valid),
        .m1_en(m1_en), .m1_rw(m1_rw), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_valid(m1_valid),
        .s_en(s_en), .s_rw(s_rw), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_valid(s_valid),
        .owner(owner), .busy(busy), .tmo(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    task automatic clear_inputs();
        m0_en = 1'b0; m0_rw = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_en = 1'b0; m1_rw = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_valid = 1'b0; s_rdata = 32'h0;
    endtask

    task automatic test_reset();
        res = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({s_en, s_rw, s_be, s_addr, s_wdata} !== 70'd0)
            $display("FAIL reset_sbus: got %h expected 0", {s_en, s_rw, s_be, s_addr, s_wdata});
        else n_pass++;
        n_checks++;
        if ({owner, busy, tmo, m0_valid, m1_valid} !== 5'b00000)
            $display("FAIL reset_status: got %b expected 00000", {owner, busy, tmo, m0_valid, m1_valid});
        else n_pass++;
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'd0)
            $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
        else n_pass++;
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_en = 1'b1; m0_rw = 1'b0; m0_be = 4'hF; m0_addr = 32'h0000_0100;
        #1;
        n_checks++;
        if (s_en !== 1'b0) $display("FAIL rd_c1_sen: got %b expected 0", s_en); else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({s_en, s_rw, s_addr, owner, busy} !== {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1})
            $display("FAIL rd_c2_grant: got %h expected %h", {s_en, s_rw, s_addr, owner, busy},
                     {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({s_en, m0_valid, m1_valid} !== 3'b100)
            $display("FAIL rd_c3_wait: got %b expected 100", {s_en, m0_valid, m1_valid});
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b1; s_rdata = 32'hCAFE_BABE;
        #1;
        n_checks++;
        if ({s_en, m0_valid, m1_valid} !== 3'b110)
            $display("FAIL rd_c4_valid: got %b expected 110", {s_en, m0_valid, m1_valid});
        else n_pass++;
        n_checks++;
        if ({m0_rdata, m1_rdata} !== {32'hCAFE_BABE, 32'h0})
            $display("FAIL rd_c4_data: got %h expected cafebabe00000000", {m0_rdata, m1_rdata});
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0; s_rdata = 32'h0; m0_en = 1'b0;
        #1;
        n_checks++;
        if ({s_en, busy, m0_valid, m0_rdata} !== 35'd0)
            $display("FAIL rd_c5_idle: got %h expected 0", {s_en, busy, m0_valid, m0_rdata});
        else n_pass++;
    endtask

    task automatic test_contention();
        logic exp_order [10];
        logic [31:0] d;
        int waited;
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        m0_en = 1'b1; m0_addr = 32'h0000_1000; m0_be = 4'hF;
        m1_en = 1'b1; m1_addr = 32'h0000_2000; m1_be = 4'hF;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk); #1;
            waited = 0;
            while (!busy && waited < 6) begin
                @(negedge clk); #1;
                waited++;
            end
            n_checks++;
            if ({busy, owner, s_addr} !== {1'b1, exp_order[g], (exp_order[g] ? 32'h0000_2000 : 32'h0000_1000)})
                $display("FAIL cont_grant%0d: got busy=%b owner=%b addr=%h expected owner=%b",
                         g, busy, owner, s_addr, exp_order[g]);
            else n_pass++;
            @(negedge clk);
            d = 32'h1000_0000 + 32'(g);
            s_valid = 1'b1; s_rdata = d;
            #1;
            n_checks++;
            if ({m0_valid, m1_valid} !== (exp_order[g] ? 2'b01 : 2'b10) ||
                (exp_order[g] ? m1_rdata : m0_rdata) !== d)
                $display("FAIL cont_done%0d: got v=%b%b r0=%h r1=%h expected owner=%b data=%h",
                         g, m0_valid, m1_valid, m0_rdata, m1_rdata, exp_order[g], d);
            else n_pass++;
            @(negedge clk);
            s_valid = 1'b0;
            if (g == 9) begin
                m0_en = 1'b0; m1_en = 1'b0;
            end
        end
    endtask

    task automatic test_write_hold();
        @(negedge clk);
        m1_en = 1'b1; m1_rw = 1'b1; m1_be = 4'b0011; m1_addr = 32'h0000_0300; m1_wdata = 32'h0000_1234;
        @(negedge clk); #1;
        n_checks++;
        if ({s_en, s_rw, s_be, s_addr, s_wdata, owner} !== {1'b1, 1'b1, 4'b0011, 32'h300, 32'h1234, 1'b1})
            $display("FAIL wr_latch: got %h expected %h", {s_en, s_rw, s_be, s_addr, s_wdata, owner},
                     {1'b1, 1'b1, 4'b0011, 32'h300, 32'h1234, 1'b1});
        else n_pass++;
        m1_en = 1'b0; m1_rw = 1'b0; m1_be = 4'hF; m1_addr = 32'h0000_0FFC; m1_wdata = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        n_checks++;
        if ({s_en, s_rw, s_be, s_addr, s_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h300, 32'h1234})
            $display("FAIL wr_hold: got %h expected %h", {s_en, s_rw, s_be, s_addr, s_wdata},
                     {1'b1, 1'b1, 4'b0011, 32'h300, 32'h1234});
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b1; s_rdata = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if ({m0_valid, m1_valid, s_be, s_wdata} !== {1'b0, 1'b1, 4'b0011, 32'h1234})
            $display("FAIL wr_done: got %h expected %h", {m0_valid, m1_valid, s_be, s_wdata},
                     {1'b0, 1'b1, 4'b0011, 32'h1234});
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0; s_rdata = 32'h0;
        #1;
        n_checks++;
        if ({busy, s_en} !== 2'b00) $display("FAIL wr_idle: got %b expected 00", {busy, s_en}); else n_pass++;
    endtask

    task automatic test_idle_svalid();
        @(negedge clk);
        s_valid = 1'b1; s_rdata = 32'h7777_7777;
        #1;
        n_checks++;
        if ({m0_valid, m1_valid, m0_rdata, m1_rdata, tmo} !== 67'd0)
            $display("FAIL idle_sv_out: got v=%b%b r0=%h r1=%h expected all 0", m0_valid, m1_valid, m0_rdata, m1_rdata);
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0; s_rdata = 32'h0;
        #1;
        n_checks++;
        if ({busy, s_en} !== 2'b00) $display("FAIL idle_sv_state: got %b expected 00", {busy, s_en}); else n_pass++;
    endtask

    task automatic test_watchdog(input logic late_valid);
        @(negedge clk);
        m0_en = 1'b1; m0_rw = 1'b0; m0_be = 4'hF; m0_addr = 32'h0000_0400;
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk);
            if (b == 8 && late_valid) begin
                s_valid = 1'b1; s_rdata = 32'h5A5A_5A5A;
            end
            #1;
            if (b < 8) begin
                n_checks++;
                if ({busy, tmo, m0_valid} !== 3'b100)
                    $display("FAIL wd_wait%0d: got %b expected 100", b, {busy, tmo, m0_valid});
                else n_pass++;
            end else if (late_valid) begin
                n_checks++;
                if ({tmo, m0_valid, m1_valid, m0_rdata} !== {3'b010, 32'h5A5A_5A5A})
                    $display("FAIL wd_tie: got tmo=%b v=%b%b r=%h expected tmo=0 v=10 r=5a5a5a5a",
                             tmo, m0_valid, m1_valid, m0_rdata);
                else n_pass++;
            end else begin
                n_checks++;
                if ({tmo, m0_valid, m1_valid, m0_rdata} !== {3'b110, 32'hFFFF_FFFF})
                    $display("FAIL wd_expire: got tmo=%b v=%b%b r=%h expected tmo=1 v=10 r=ffffffff",
                             tmo, m0_valid, m1_valid, m0_rdata);
                else n_pass++;
            end
        end
        @(negedge clk);
        m0_en = 1'b0; s_valid = 1'b0; s_rdata = 32'h0;
        #1;
        n_checks++;
        if ({busy, s_en, tmo, m0_valid} !== 4'b0000)
            $display("FAIL wd_after: got %b expected 0000", {busy, s_en, tmo, m0_valid});
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        int waited;
        @(negedge clk);
        m0_en = 1'b1; m0_addr = 32'h0000_0500; m1_en = 1'b1; m1_addr = 32'h0000_0600;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk); #1;
            waited = 0;
            while (!busy && waited < 6) begin
                @(negedge clk); #1;
                waited++;
            end
            n_checks++;
            if ({busy, owner} !== 2'b11)
                $display("FAIL rb_pre%0d: got busy/owner %b expected 11", g, {busy, owner});
            else n_pass++;
            if (g < 3) begin
                @(negedge clk); s_valid = 1'b1;
                @(negedge clk); s_valid = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        #1;
        n_checks++;
        if ({m0_valid, m1_valid} !== 2'b00)
            $display("FAIL rb_novalid: got %b expected 00", {m0_valid, m1_valid});
        else n_pass++;
        @(negedge clk);
        res = 1'b1;
        #1;
        n_checks++;
        if ({s_en, busy, m0_valid, m1_valid} !== 4'b0000)
            $display("FAIL rb_after: got %b expected 0000", {s_en, busy, m0_valid, m1_valid});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({busy, owner, s_addr} !== {1'b1, 1'b1, 32'h0000_0600})
            $display("FAIL rb_tie_m1: got busy=%b owner=%b addr=%h expected 1 1 00000600", busy, owner, s_addr);
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b1; s_rdata = 32'h0000_00AB;
        #1;
        n_checks++;
        if ({m0_valid, m1_valid, m1_rdata} !== {2'b01, 32'h0000_00AB})
            $display("FAIL rb_done: got v=%b%b r=%h expected 01 000000ab", m0_valid, m1_valid, m1_rdata);
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0; m0_en = 1'b0; m1_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_hold();
        test_idle_svalid();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_reset_busy();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
